pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised fetch program-counter unit driving the instruction-memory address, with prioritised next-PC selection and a small return-address stack (RAS) for predicted returns. It sits at the head of the IF stage and takes stall, redirect and trap requests from the hazard, branch and exception logic. All state changes on the rising edge only.

## Interface
- XLEN, 32, address width in bits
- RESET_VECTOR, 0, PC value loaded on reset
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap
- INST_BYTES, 4, sequential increment and alignment unit (power of two)
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- stall  in  1  hold PC (load-use hazard)
- redirect_valid  in  1  resolved branch/jump or mispredicted return correction
- redirect_target  in  XLEN  redirect destination
- trap_valid  in  1  exception/interrupt entry
- call  in  1  predecoded call at current pc (push pc+INST_BYTES)
- ret  in  1  predecoded return at current pc (predict from RAS)
- pc  out  XLEN  instruction fetch address (registered)
- flush  out  1  kill IF/ID contents; registered, high the cycle after a redirect or trap is taken
- misaligned  out  1  registered; high the cycle after a redirect whose target is not INST_BYTES-aligned
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries

## Operation
- Next-PC priority, evaluated each cycle:
  1. trap_valid → TRAP_VECTOR; RAS cleared (count 0)
  2. redirect_valid → redirect_target with low log2(INST_BYTES) bits forced to 0; RAS untouched
  3. stall → pc held; call/ret ignored
  4. ret with ras_count>0 → RAS top (pop)
  5. otherwise → pc + INST_BYTES (modulo 2^XLEN, wraps to 0)
- ret with ras_count==0: treated as sequential; no pop.
- call pushes pc+INST_BYTES only when neither trap, redirect nor stall is active.
- call and ret in the same cycle (count>0): top replaced by pc+INST_BYTES, next PC = old top, count unchanged; with count==0: plain push, sequential next PC.
- Push when full: circular overwrite of oldest entry, count saturates at RAS_DEPTH.
- Pop decrements count; top pointer wraps modulo RAS_DEPTH.
- flush = registered (trap_valid | redirect_valid). misaligned = registered (redirect_valid & ~trap_valid & target low bits ≠ 0).

## Timing
- Reset (async, immediate): pc=RESET_VECTOR, flush=0, misaligned=0, ras_count=0, top pointer=0; RAS entries need no reset.
- One-cycle latency: request sampled at edge N appears on pc after edge N.
- All inputs are single-cycle-sampled levels; no handshake. Held redirect_valid re-loads the target every cycle.
- Reset deasserted mid-operation: first edge after release performs a normal update from RESET_VECTOR.
- pc never changes except at a rising clock edge or on reset.

## Structure
- Shared package: XLEN, INST_BYTES, RESET_VECTOR, TRAP_VECTOR defaults and a next-PC-source enum (TRAP, REDIRECT, HOLD, RAS, SEQ).
- One sub-module: ras_stack (circular buffer: push, pop, replace, clear, count, top).
- Next-PC mux and priority logic stay in pc_unit.

## Test plan
- Reset then 3 free-running cycles → pc = 0, 4, 8, 12; flush 0.
- pc=0x40, stall for 2 cycles with call=1 → pc stays 0x40, ras_count stays 0.
- pc=0x10 call → pc 0x14, RAS top 0x14; later ret at pc=0x80 → pc 0x14, ras_count back to 0.
- redirect_valid=1 target 0x202 with stall=1 → pc 0x200 next cycle, flush=1, misaligned=1, RAS unchanged.
- trap_valid and redirect_valid together with ras_count=3 → pc=TRAP_VECTOR, ras_count=0, flush=1, misaligned=0.
- RAS_DEPTH=4: 5 calls from 0x0,0x10,0x20,0x30,0x40 then 5 rets → returns 0x44,0x34,0x24,0x14, fifth ret sequential; pc at 0xFFFFFFFC sequential → wraps to 0.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared defaults and the next-PC source encoding for the fetch PC unit.
package pc_unit_pkg;

  localparam int          XLEN_DEF         = 32;
  localparam int          INST_BYTES_DEF   = 4;
  localparam int          RAS_DEPTH_DEF    = 4;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

  // Winning source of the next fetch address, highest priority first.
  typedef enum logic [2:0] {
    SRC_TRAP,
    SRC_REDIRECT,
    SRC_HOLD,
    SRC_RAS,
    SRC_SEQ
  } next_src_e;

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack. The top pointer indexes the newest entry;
// pushing past capacity overwrites the oldest entry and saturates the count.
module pc_unit_ras_stack #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  top,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] top_ptr;
  logic          replace;

  // push+pop on a non-empty stack swaps the top entry in place
  assign replace = push && pop && (count != '0);
  assign top     = mem[top_ptr];

  // entry storage: written on replace (at top) or push (one above top)
  always_ff @(posedge clock) begin
    if (!clear) begin
      if (replace)   mem[top_ptr]              <= push_data;
      else if (push) mem[top_ptr + PW'(1)]     <= push_data;
    end
  end

  // pointer and occupancy tracking
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (clear) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (replace) begin
      top_ptr <= top_ptr;
    end else if (push) begin
      top_ptr <= top_ptr + PW'(1);
      if (count != CW'(DEPTH)) count <= count + CW'(1);
    end else if (pop && count != '0) begin
      top_ptr <= top_ptr - PW'(1);
      count   <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with prioritised next-PC selection and a return-address
// stack for predicted returns. Drives the instruction-memory address.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
  parameter int              INST_BYTES   = INST_BYTES_DEF,
  parameter int              RAS_DEPTH    = RAS_DEPTH_DEF,
  localparam int             CW           = $clog2(RAS_DEPTH) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic            call,
  input  logic            ret,
  output logic [XLEN-1:0] pc,
  output logic            flush,
  output logic            misaligned,
  output logic [CW-1:0]   ras_count
);

  localparam logic [XLEN-1:0] LOW_BITS = XLEN'(INST_BYTES - 1);

  next_src_e       src;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] ras_top;
  logic            ras_push;
  logic            ras_pop;
  logic            target_unaligned;

  assign seq_pc           = pc + XLEN'(INST_BYTES);
  assign target_unaligned = |(redirect_target & LOW_BITS);

  // priority select; RAS only moves when fetch actually advances
  always_comb begin
    src = SRC_SEQ;
    if (trap_valid)                        src = SRC_TRAP;
    else if (redirect_valid)               src = SRC_REDIRECT;
    else if (stall)                        src = SRC_HOLD;
    else if (ret && ras_count != '0)       src = SRC_RAS;

    ras_push = call && (src == SRC_RAS || src == SRC_SEQ);
    ras_pop  = (src == SRC_RAS);

    next_pc = seq_pc;
    case (src)
      SRC_TRAP:     next_pc = TRAP_VECTOR;
      SRC_REDIRECT: next_pc = redirect_target & ~LOW_BITS;
      SRC_HOLD:     next_pc = pc;
      SRC_RAS:      next_pc = ras_top;
      default:      next_pc = seq_pc;
    endcase
  end

  // PC and status outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc         <= RESET_VECTOR;
      flush      <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      pc         <= next_pc;
      flush      <= trap_valid | redirect_valid;
      misaligned <= redirect_valid & ~trap_valid & target_unaligned;
    end
  end

  pc_unit_ras_stack #(
    .W     (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .clear     (trap_valid),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq_pc),
    .top       (ras_top),
    .count     (ras_count)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Randomised and directed bench for pc_unit against a queue-based fetch model.
module tb_pc_unit;

  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
  localparam int          DEPTH    = 4;

  logic        clock = 0;
  logic        reset;
  logic        stall, redirect_valid, trap_valid, call, ret;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic        flush, misaligned;
  logic [2:0]  ras_count;

  pc_unit dut (
    .clock(clock), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .call(call), .ret(ret),
    .pc(pc), .flush(flush), .misaligned(misaligned), .ras_count(ras_count)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // reference state
  logic [31:0] m_pc;
  logic        m_flush, m_mis;
  logic [31:0] m_ras[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    stall = 0; redirect_valid = 0; trap_valid = 0; call = 0; ret = 0;
    redirect_target = '0;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_flush = 0; m_mis = 0; m_ras.delete();
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    pc,                m_pc);
    chk({tag, ".flush"}, 32'(flush),        32'(m_flush));
    chk({tag, ".mis"},   32'(misaligned),   32'(m_mis));
    chk({tag, ".cnt"},   32'(ras_count),    32'(m_ras.size()));
  endtask

  // advance one clock: model computes from current inputs, then compare
  task automatic cycle(input string tag);
    logic [31:0] seq;
    logic [31:0] npc;
    seq = m_pc + 32'd4;
    m_flush = trap_valid | redirect_valid;
    m_mis   = 0;
    if (trap_valid) begin
      npc = TRAP_VEC; m_ras.delete();
    end else if (redirect_valid) begin
      npc = {redirect_target[31:2], 2'b00};
      m_mis = (redirect_target[1:0] != 2'b00);
    end else if (stall) begin
      npc = m_pc;
    end else if (ret && m_ras.size() > 0) begin
      npc = m_ras[$];
      if (call) m_ras[m_ras.size()-1] = seq;
      else void'(m_ras.pop_back());
    end else begin
      npc = seq;
      if (call) begin
        m_ras.push_back(seq);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
    end
    m_pc = npc;
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic go_to(input logic [31:0] a);
    idle(); redirect_valid = 1; redirect_target = a;
    cycle("goto");
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clock); reset = 0;

    // free-running sequential fetch
    cycle("seq1"); chk("seq1.abs", pc, 32'd4);
    cycle("seq2"); chk("seq2.abs", pc, 32'd8);
    cycle("seq3"); chk("seq3.abs", pc, 32'd12);

    // stall blocks both PC and call pushes
    go_to(32'h40);
    stall = 1; call = 1;
    cycle("stall1"); cycle("stall2");
    chk("stall.pc", pc, 32'h40); chk("stall.cnt", 32'(ras_count), 0);
    idle();

    // call then later return
    go_to(32'h10);
    call = 1; cycle("call"); idle();
    chk("call.pc", pc, 32'h14); chk("call.cnt", 32'(ras_count), 1);
    go_to(32'h80);
    ret = 1; cycle("ret"); idle();
    chk("ret.pc", pc, 32'h14); chk("ret.cnt", 32'(ras_count), 0);

    // misaligned redirect beats stall
    call = 1; cycle("push1"); idle();
    redirect_valid = 1; redirect_target = 32'h202; stall = 1;
    cycle("redir"); idle();
    chk("redir.pc", pc, 32'h200); chk("redir.flush", 32'(flush), 1);
    chk("redir.mis", 32'(misaligned), 1); chk("redir.cnt", 32'(ras_count), 1);

    // trap beats redirect and clears the RAS
    call = 1; cycle("push2"); cycle("push3"); idle();
    chk("pre_trap.cnt", 32'(ras_count), 3);
    trap_valid = 1; redirect_valid = 1; redirect_target = 32'h303;
    cycle("trap"); idle();
    chk("trap.pc", pc, TRAP_VEC); chk("trap.cnt", 32'(ras_count), 0);
    chk("trap.flush", 32'(flush), 1); chk("trap.mis", 32'(misaligned), 0);

    // overflow: five calls into a four-deep stack
    for (int i = 0; i < 5; i++) begin
      go_to(32'(i * 16));
      call = 1; cycle("ovf_call"); idle();
    end
    chk("ovf.cnt", 32'(ras_count), 4);
    ret = 1;
    cycle("ovf_r1"); chk("ovf_r1.abs", pc, 32'h44);
    cycle("ovf_r2"); chk("ovf_r2.abs", pc, 32'h34);
    cycle("ovf_r3"); chk("ovf_r3.abs", pc, 32'h24);
    cycle("ovf_r4"); chk("ovf_r4.abs", pc, 32'h14);
    cycle("ovf_r5"); chk("ovf_r5.abs", pc, 32'h18);
    idle();

    // call+ret together
    go_to(32'h500); call = 1; cycle("cr_push"); idle();
    go_to(32'h600); call = 1; ret = 1; cycle("cr_both"); idle();
    chk("cr.pc", pc, 32'h504); chk("cr.cnt", 32'(ras_count), 1);
    ret = 1; cycle("cr_pop"); idle();
    chk("cr_pop.pc", pc, 32'h604);

    // address wrap
    go_to(32'hFFFF_FFFC);
    cycle("wrap"); chk("wrap.abs", pc, 32'h0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      trap_valid      = ($urandom_range(0, 39) == 0);
      redirect_valid  = ($urandom_range(0, 7) == 0);
      redirect_target = $urandom;
      stall           = ($urandom_range(0, 4) == 0);
      call            = ($urandom_range(0, 3) == 0);
      ret             = ($urandom_range(0, 3) == 0);
      cycle("rand");
    end
    idle();

    // asynchronous reset mid-operation, then resume
    go_to(32'h1234);
    #3 reset = 1; model_reset();
    #1 check_all("areset");
    @(negedge clock); reset = 0;
    cycle("post_rst"); chk("post_rst.abs", pc, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
